// File: rtl/bcd_updown_timer_pkg.sv
// Shared constants, action encoding and helpers for the BCD up/down timer.
// Imported by the digit slice and the top.
package bcd_updown_timer_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_MIN = 4'd0;

    // Winning action for one cycle, highest priority first.
    typedef enum logic [1:0] {
        ACT_CLR   = 2'd0,
        ACT_LOAD  = 2'd1,
        ACT_START = 2'd2,
        ACT_STEP  = 2'd3
    } act_e;

    function automatic act_e pick_act(
        input logic clr,
        input logic ld,
        input logic start
    );
        act_e a;
        priority case (1'b1)
            clr:     a = ACT_CLR;
            ld:      a = ACT_LOAD;
            start:   a = ACT_START;
            default: a = ACT_STEP;
        endcase
        return a;
    endfunction

    function automatic logic [3:0] bcd_sat(input logic [3:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_updown_timer_bcd_digit.sv
// One BCD digit register with clear, load, inc and dec enables.
// Ripple enables come from the parent, already gated by lower digits.
module bcd_digit
    import bcd_updown_timer_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clr_i,
    input  logic       ld_i,
    input  logic [3:0] ld_val_i,
    input  logic       inc_i,
    input  logic       dec_i,
    output logic [3:0] val_o,
    output logic       at_max_o,
    output logic       at_min_o
);

    logic [3:0] val_q;
    logic [3:0] val_d;

    always_comb begin
        val_d = val_q;
        priority case (1'b1)
            clr_i: val_d = BCD_MIN;
            ld_i:  val_d = bcd_sat(ld_val_i);
            inc_i: val_d = at_max_o ? BCD_MIN : val_q + 4'd1;
            dec_i: val_d = at_min_o ? BCD_MAX : val_q - 4'd1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            val_q <= BCD_MIN;
        end else begin
            val_q <= val_d;
        end
    end

    assign val_o    = val_q;
    assign at_max_o = (val_q == BCD_MAX);
    assign at_min_o = (val_q == BCD_MIN);

endmodule

// File: rtl/bcd_updown_timer.sv
// Multi-digit BCD up/down timer: prescaled run tick, manual step, load,
// countdown alarm with auto-stop, and carry/borrow pulses for cascading.
module bcd_updown_timer
    import bcd_updown_timer_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 25175000,
    parameter int PW       = 25
) (
    input  logic                MCLK,
    input  logic                RST_N,
    input  logic                START,
    input  logic                CLR,
    input  logic                LOAD,
    input  logic [4*DIGITS-1:0] LOAD_VAL,
    input  logic                UP,
    input  logic                INC,
    input  logic                DEC,
    output logic [4*DIGITS-1:0] Q,
    output logic                RUN,
    output logic                ZERO,
    output logic                ALARM,
    output logic                CARRY,
    output logic                BORROW
);

    localparam int QW = 4 * DIGITS;
    localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);

    act_e          act;
    logic          tick;
    logic          step_up;
    logic          step_dn;
    logic          term;
    logic [DIGITS:0] cin;
    logic [DIGITS:0] bin;
    logic [DIGITS-1:0] at_max;
    logic [DIGITS-1:0] at_min;

    logic [PW-1:0] presc_q, presc_d;
    logic          run_q, run_d;
    logic          alarm_q, alarm_d;
    logic          carry_q, carry_d;
    logic          borrow_q, borrow_d;

    assign act  = pick_act(CLR, LOAD, START);
    assign tick = run_q && (presc_q == PS_LAST);
    assign ZERO = (Q == '0);

    // A running down-tick from 1 lands on 0 and stops instead of wrapping.
    assign term = (act == ACT_STEP) && tick && !UP && (Q == QW'(1));

    always_comb begin
        step_up = 1'b0;
        step_dn = 1'b0;
        if (act == ACT_STEP) begin
            if (run_q) begin
                step_up = tick && UP;
                step_dn = tick && !UP;
            end else begin
                step_up = INC && !DEC;
                step_dn = DEC && !INC;
            end
        end
    end

    assign cin[0] = step_up;
    assign bin[0] = step_dn;

    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        logic [3:0] val;

        bcd_digit u_digit (
            .clk_i    (MCLK),
            .rst_ni   (RST_N),
            .clr_i    (act == ACT_CLR),
            .ld_i     (act == ACT_LOAD),
            .ld_val_i (LOAD_VAL[4*i +: 4]),
            .inc_i    (cin[i]),
            .dec_i    (bin[i]),
            .val_o    (val),
            .at_max_o (at_max[i]),
            .at_min_o (at_min[i])
        );

        assign Q[4*i +: 4] = val;
        assign cin[i+1]    = cin[i] & at_max[i];
        assign bin[i+1]    = bin[i] & at_min[i];
    end

    always_comb begin
        run_d    = run_q;
        alarm_d  = alarm_q;
        presc_d  = presc_q;
        carry_d  = 1'b0;
        borrow_d = 1'b0;
        unique case (act)
            ACT_CLR: begin
                run_d   = 1'b0;
                alarm_d = 1'b0;
                presc_d = '0;
            end
            ACT_LOAD: begin
                alarm_d = 1'b0;
                presc_d = '0;
            end
            ACT_START: begin
                alarm_d = 1'b0;
                presc_d = '0;
                // Nothing to count down from zero, so stay stopped.
                run_d   = run_q ? 1'b0 : (UP || !ZERO);
            end
            ACT_STEP: begin
                if (run_q) begin
                    presc_d = tick ? '0 : presc_q + PW'(1);
                end else begin
                    presc_d = '0;
                end
                if (term) begin
                    run_d   = 1'b0;
                    alarm_d = 1'b1;
                    presc_d = '0;
                end
                carry_d  = cin[DIGITS];
                borrow_d = bin[DIGITS];
            end
            default: ;
        endcase
    end

    always_ff @(posedge MCLK or negedge RST_N) begin
        if (!RST_N) begin
            presc_q  <= '0;
            run_q    <= 1'b0;
            alarm_q  <= 1'b0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            run_q    <= run_d;
            alarm_q  <= alarm_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
        end
    end

    assign RUN    = run_q;
    assign ALARM  = alarm_q;
    assign CARRY  = carry_q;
    assign BORROW = borrow_q;

endmodule
